// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED controller.
// - led_mode_e : 2-bit channel mode (OFF, ON, BLINK, PWM)
// - ALPACACORN_CONFIG_ID : board identification pattern shown out of reset
// - reset_mode() : maps one CONFIG_ID bit to the channel's reset mode
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    LED_MODE_OFF   = 2'd0,
    LED_MODE_ON    = 2'd1,
    LED_MODE_BLINK = 2'd2,
    LED_MODE_PWM   = 2'd3
  } led_mode_e;

  localparam logic [15:0] ALPACACORN_CONFIG_ID = 16'h0055;

  function automatic led_mode_e reset_mode(input logic on);
    return on ? LED_MODE_ON : LED_MODE_OFF;
  endfunction

endpackage

// File: rtl/led_ctrl_if.sv
// Peripheral-bus port of the LED controller.
// - we_i    : write strobe
// - addr_i  : channel select
// - wdata_i : {duty, mode}
// - rdata_o : registered {duty, mode} readback of the channel at addr_i
interface led_ctrl_if #(
  parameter int unsigned PWM_BITS = 8
);
  logic                  we_i;
  logic [3:0]            addr_i;
  logic [PWM_BITS+1:0]   wdata_i;
  logic [PWM_BITS+1:0]   rdata_o;

  modport master (output we_i, output addr_i, output wdata_i, input rdata_o);
  modport slave  (input we_i, input addr_i, input wdata_i, output rdata_o);
endinterface

// File: rtl/led_ctrl_channel.sv
// One LED channel: mode/duty registers plus the registered LED drive bit.
// - clk_i, rst_i    : clock, synchronous active-high reset
// - we_i            : write strobe already decoded for this channel
// - wdata_i         : {duty, mode}
// - pwm_cnt_i       : shared PWM counter
// - blink_phase_i   : shared blink phase
// - cfg_o           : current {duty, mode} for readback
// - led_o           : registered LED output
module led_ctrl_channel
  import led_ctrl_pkg::*;
#(
  parameter int unsigned PWM_BITS = 8,
  parameter logic        RST_ON   = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                we_i,
  input  logic [PWM_BITS+1:0] wdata_i,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  input  logic                blink_phase_i,
  output logic [PWM_BITS+1:0] cfg_o,
  output logic                led_o
);

  led_mode_e           mode_q;
  logic [PWM_BITS-1:0] duty_q;
  logic                led_d;
  logic                led_q;

  always_comb begin
    led_d = 1'b0;
    unique case (mode_q)
      LED_MODE_OFF:   led_d = 1'b0;
      LED_MODE_ON:    led_d = 1'b1;
      LED_MODE_BLINK: led_d = blink_phase_i;
      LED_MODE_PWM:   led_d = (pwm_cnt_i < duty_q);
      default:        led_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q <= reset_mode(RST_ON);
      duty_q <= '0;
      led_q  <= 1'b0;
    end else begin
      // Output is computed from the pre-write state, giving one cycle of
      // write-to-LED latency.
      led_q <= led_d;
      if (we_i) begin
        mode_q <= led_mode_e'(wdata_i[1:0]);
        duty_q <= wdata_i[PWM_BITS+1:2];
      end
    end
  end

  assign cfg_o = {duty_q, mode_q};
  assign led_o = led_q;

endmodule

// File: rtl/led_ctrl.sv
// Register-programmable LED controller, N_LEDS channels of OFF/ON/BLINK/PWM.
// - clk_i, rst_i : clock, synchronous active-high reset
// - bus          : write/read port (led_ctrl_if slave)
// - tick_o       : registered one-cycle pulse per PWM tick
// - led_o        : registered LED drive, active-high
// Holds the shared prescaler, PWM counter, blink counter and readback mux.
module led_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int unsigned N_LEDS      = 7,
  parameter logic [15:0] CONFIG_ID   = ALPACACORN_CONFIG_ID,
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned PRESCALE    = 16,
  parameter int unsigned BLINK_WRAPS = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  led_ctrl_if.slave         bus,
  output logic              tick_o,
  output logic [N_LEDS-1:0] led_o
);

  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned BW   = (BLINK_WRAPS > 1) ? $clog2(BLINK_WRAPS) : 1;

  logic [PS_W-1:0]     prescale_cnt_q, prescale_cnt_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [BW-1:0]       blink_cnt_q, blink_cnt_d;
  logic                blink_phase_q, blink_phase_d;
  logic                tick_q, tick_d;
  logic                wrap;
  logic                blink_last;
  logic [PWM_BITS+1:0] rdata_q, rdata_d;
  logic [PWM_BITS+1:0] cfg [N_LEDS];

  always_comb begin
    tick_d         = (prescale_cnt_q == PS_W'(PRESCALE - 1));
    prescale_cnt_d = tick_d ? '0 : prescale_cnt_q + PS_W'(1);
    pwm_cnt_d      = tick_d ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
    wrap           = tick_d && (&pwm_cnt_q);
    blink_last     = (blink_cnt_q == BW'(BLINK_WRAPS - 1));
    blink_cnt_d    = blink_cnt_q;
    blink_phase_d  = blink_phase_q;
    if (wrap) begin
      blink_cnt_d   = blink_last ? '0 : blink_cnt_q + BW'(1);
      blink_phase_d = blink_phase_q ^ blink_last;
    end
  end

  // Unmatched (out-of-range) addresses fall through to zero.
  always_comb begin
    rdata_d = '0;
    for (int unsigned i = 0; i < N_LEDS; i++) begin
      if (bus.addr_i == 4'(i)) rdata_d = cfg[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prescale_cnt_q <= '0;
      pwm_cnt_q      <= '0;
      blink_cnt_q    <= '0;
      blink_phase_q  <= 1'b0;
      tick_q         <= 1'b0;
      rdata_q        <= '0;
    end else begin
      prescale_cnt_q <= prescale_cnt_d;
      pwm_cnt_q      <= pwm_cnt_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_phase_q  <= blink_phase_d;
      tick_q         <= tick_d;
      rdata_q        <= rdata_d;
    end
  end

  for (genvar g = 0; g < N_LEDS; g++) begin : g_ch
    led_ctrl_channel #(
      .PWM_BITS (PWM_BITS),
      .RST_ON   (CONFIG_ID[g])
    ) u_ch (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .we_i          (bus.we_i && (bus.addr_i == 4'(g))),
      .wdata_i       (bus.wdata_i),
      .pwm_cnt_i     (pwm_cnt_q),
      .blink_phase_i (blink_phase_q),
      .cfg_o         (cfg[g]),
      .led_o         (led_o[g])
    );
  end

  assign tick_o      = tick_q;
  assign bus.rdata_o = rdata_q;

endmodule
